mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory stage of the single-cycle-derived Y86-64 datapath. It sits directly downstream of the execute stage and consumes its ALU result (valE) plus the pass-through valA/valP.
- Performs the Y86 data-memory access (read or write) over a variable-latency req/ack memory port. Produces valM and the updated instruction status.
- Multi-cycle. The control unit holds the pipeline while busy_o is high.

Parameters:
- MEM_BYTES, 8192: size of the data memory in bytes. An access is legal only if addr + 8 <= MEM_BYTES.
- TIMEOUT, 16: maximum REQ-state cycles without mem_ack_i before the access is aborted with ADR.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  one-cycle request from execute; instruction fields valid this cycle
- icode_i  in  4  instruction code (HALT=0, RMMOVQ=4, MRMOVQ=5, CALL=8, RET=9, PUSHQ=A, POPQ=B)
- stat_i  in  3  incoming status (AOK=1, HLT=2, ADR=3, INS=4)
- valE_i  in  64  ALU result from execute
- valA_i  in  64  register operand A
- valP_i  in  64  next-PC value (return address for CALL)
- mem_req_o  out  1  memory request, held until ack
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  64  byte address
- mem_wdata_o  out  64  write data
- mem_ack_i  in  1  memory completion
- mem_err_i  in  1  memory fault; valid with ack
- mem_rdata_i  in  64  read data; valid with ack
- valM_o  out  64  read result; held until next start
- stat_o  out  3  resulting status; held until next start
- done_o  out  1  one-cycle completion pulse
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- States: IDLE, REQ, DONE. busy_o = (state != IDLE). done_o = (state == DONE).
- Reset (async, rst_n_i=0):
  - State goes to IDLE immediately; mem_req_o drops in the same instant.
  - All outputs reset to 0, except stat_o = AOK (1). Timeout counter is cleared.
- IDLE, start_i=1 at edge N:
  - Latch icode, stat, addr, wdata and we.
  - addr: valA_i for POPQ and RET; valE_i for RMMOVQ, MRMOVQ, PUSHQ and CALL.
  - wdata: valA_i for RMMOVQ and PUSHQ; valP_i for CALL.
  - we = 1 for RMMOVQ, PUSHQ and CALL; we = 0 for MRMOVQ, POPQ and RET.
  - valM_o is cleared to 0.
- IDLE, start_i=1: routing.
  - stat_i != AOK: go to DONE. No request issued; stat_o = stat_i.
  - icode is not a memory op: go to DONE with stat_o = AOK.
  - Bounds fail (addr > MEM_BYTES-8, unsigned compare, computed without 64-bit overflow): go to DONE with stat_o = ADR. No request issued.
  - Otherwise: go to REQ.
- start_i outside IDLE is ignored.
- REQ:
  - mem_req_o=1; mem_addr_o, mem_we_o and mem_wdata_o are stable for the whole state.
  - Timeout counter increments each REQ cycle.
  - ack=1, err=0: for reads, valM_o <= mem_rdata_i; stat_o = AOK; go to DONE.
  - ack=1, err=1: stat_o = ADR; valM_o = 0; go to DONE.
  - No ack and counter == TIMEOUT-1: drop the request, stat_o = ADR, go to DONE. An ack arriving in that same cycle wins over the timeout.
- DONE: exactly one cycle, then IDLE. The counter is cleared on leaving REQ.
- Latency:
  - Non-memory or rejected instruction: done_o is high in cycle N+1.
  - Zero-wait memory (ack in the first REQ cycle): done_o is high in cycle N+2.
  - Each memory wait cycle adds one.
- Outside REQ, mem_req_o=0 and mem_we_o=0. mem_addr_o and mem_wdata_o hold their last values.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined: a memory op with addr[2:0] != 0 is rejected at start. It goes to DONE with stat_o = ADR and no request is issued; bounds and alignment are checked in the same cycle.
- Undefined: no alignment check; unaligned addresses are passed to the memory unchanged.

Test Plan:
- MRMOVQ, valE=0x100, ack on the first REQ cycle with rdata=0xDEADBEEF: addr=0x100 and we=0 in cycle N+1; valM_o=0xDEADBEEF, stat_o=1 and done_o pulse in cycle N+2.
- CALL, valE=0x1F8, valP=0x40, ack after 3 wait cycles: we=1 and wdata=0x40 held for 4 cycles; done_o at N+5; stat_o=1.
- POPQ, valA=MEM_BYTES-4: no mem_req_o; done_o at N+1; stat_o=3 (ADR).
- RMMOVQ with ack never returned: mem_req_o high for exactly 16 cycles, then done_o with stat_o=3.
- stat_i=4 (INS) with PUSHQ: no request; stat_o=4 at N+1. OPQ with stat_i=1: stat_o=1 at N+1, valM_o=0.
- rst_n_i pulled low mid-REQ: mem_req_o=0 with no clock edge. After release: IDLE, busy_o=0, stat_o=1. With MEM_ALIGN_CHECK_EN: MRMOVQ to 0x103 gives stat_o=3 at N+1 with no request.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Variable-latency req/ack data-memory port used by the Y86-64 memory stage.
// The stage drives the request side (master); the memory model or controller answers on the slave side.
interface mem_access_stage_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic        mem_ack_i;
  logic        mem_err_i;
  logic [63:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_wdata_o,
    input  mem_ack_i,
    input  mem_err_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_wdata_o,
    output mem_ack_i,
    output mem_err_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/mem_access_stage.sv
// Y86-64 memory stage: one data-memory access per start over a req/ack port, yielding valM and status.
// Optional macro MEM_ALIGN_CHECK_EN rejects memory ops whose address is not 8-byte aligned.
module mem_access_stage #(
  parameter int unsigned MEM_BYTES = 8192,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic [3:0]          icode_i,
  input  logic [2:0]          stat_i,
  input  logic [63:0]         valE_i,
  input  logic [63:0]         valA_i,
  input  logic [63:0]         valP_i,
  mem_access_stage_if.master  mem,
  output logic [63:0]         valM_o,
  output logic [2:0]          stat_o,
  output logic                done_o,
  output logic                busy_o
);

  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] ST_AOK = 3'd1;
  localparam logic [2:0] ST_ADR = 3'd3;

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  // Highest legal start address; addr + 8 is never formed, so no 64-bit wrap.
  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_mem_op(input logic [3:0] ic);
    case (ic)
      I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: is_mem_op = 1'b1;
      default:                                            is_mem_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_read_op(input logic [3:0] ic);
    case (ic)
      I_MRMOVQ, I_RET, I_POPQ: is_read_op = 1'b1;
      default:                 is_read_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_write_op(input logic [3:0] ic);
    case (ic)
      I_RMMOVQ, I_PUSHQ, I_CALL: is_write_op = 1'b1;
      default:                   is_write_op = 1'b0;
    endcase
  endfunction

  state_t           state_r;
  state_t           state_nx_s;
  logic [3:0]       icode_r;
  logic [63:0]      addr_r;
  logic [63:0]      wdata_r;
  logic             we_r;
  logic [63:0]      valm_r;
  logic [2:0]       stat_r;
  logic [CNT_W-1:0] cnt_r;

  logic [63:0]      addr_sel_s;
  logic [63:0]      wdata_sel_s;
  logic             addr_bad_s;
  logic [2:0]       start_stat_s;
  logic             start_req_s;

  // Start-time operand selection and routing decision.
  always_comb begin
    addr_sel_s   = valE_i;
    wdata_sel_s  = valA_i;
    addr_bad_s   = 1'b0;
    start_stat_s = ST_AOK;
    start_req_s  = 1'b0;
    if ((icode_i == I_POPQ) || (icode_i == I_RET)) begin
      addr_sel_s = valA_i;
    end else begin
      addr_sel_s = valE_i;
    end
    if (icode_i == I_CALL) begin
      wdata_sel_s = valP_i;
    end else begin
      wdata_sel_s = valA_i;
    end
`ifdef MEM_ALIGN_CHECK_EN
    addr_bad_s = (addr_sel_s > ADDR_MAX) || (addr_sel_s[2:0] != 3'd0);
`else
    addr_bad_s = (addr_sel_s > ADDR_MAX);
`endif
    if (stat_i != ST_AOK) begin
      start_stat_s = stat_i;
      start_req_s  = 1'b0;
    end else if (!is_mem_op(icode_i)) begin
      start_stat_s = ST_AOK;
      start_req_s  = 1'b0;
    end else if (addr_bad_s) begin
      start_stat_s = ST_ADR;
      start_req_s  = 1'b0;
    end else begin
      start_stat_s = ST_AOK;
      start_req_s  = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; an ack in the last timeout cycle still completes normally.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_i) begin
          state_nx_s = start_req_s ? S_REQ : S_DONE;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem.mem_ack_i || (cnt_r == CNT_LAST)) begin
          state_nx_s = S_DONE;
        end else begin
          state_nx_s = S_REQ;
        end
      end
      S_DONE:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Latched access fields, result registers and timeout counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      icode_r <= 4'd0;
      addr_r  <= 64'd0;
      wdata_r <= 64'd0;
      we_r    <= 1'b0;
      valm_r  <= 64'd0;
      stat_r  <= ST_AOK;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          cnt_r <= '0;
          if (start_i) begin
            icode_r <= icode_i;
            addr_r  <= addr_sel_s;
            wdata_r <= wdata_sel_s;
            we_r    <= is_write_op(icode_i);
            valm_r  <= 64'd0;
            stat_r  <= start_stat_s;
          end
        end
        S_REQ: begin
          if (mem.mem_ack_i) begin
            cnt_r <= '0;
            if (mem.mem_err_i) begin
              stat_r <= ST_ADR;
              valm_r <= 64'd0;
            end else begin
              stat_r <= ST_AOK;
              if (is_read_op(icode_r)) begin
                valm_r <= mem.mem_rdata_i;
              end
            end
          end else if (cnt_r == CNT_LAST) begin
            cnt_r  <= '0;
            stat_r <= ST_ADR;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_DONE:  cnt_r <= '0;
        default: cnt_r <= '0;
      endcase
    end
  end

  // Outputs decoded from registered state so reset drops the request at once.
  always_comb begin
    mem.mem_req_o   = 1'b0;
    mem.mem_we_o    = 1'b0;
    mem.mem_addr_o  = addr_r;
    mem.mem_wdata_o = wdata_r;
    valM_o          = valm_r;
    stat_o          = stat_r;
    busy_o          = 1'b0;
    done_o          = 1'b0;
    case (state_r)
      S_IDLE: begin
        busy_o = 1'b0;
      end
      S_REQ: begin
        mem.mem_req_o = 1'b1;
        mem.mem_we_o  = we_r;
        busy_o        = 1'b1;
      end
      S_DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; the bench plays the memory side.
// Honours MEM_ALIGN_CHECK_EN for the unaligned-address step.
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  icode;
  logic [2:0]  stat_in;
  logic [63:0] val_e;
  logic [63:0] val_a;
  logic [63:0] val_p;
  logic [63:0] val_m;
  logic [2:0]  stat_out;
  logic        done;
  logic        busy;

  int total = 0;
  int bad   = 0;

  mem_access_stage_if mif ();

  mem_access_stage #(.MEM_BYTES(8192), .TIMEOUT(16)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .start_i (start),
    .icode_i (icode),
    .stat_i  (stat_in),
    .valE_i  (val_e),
    .valA_i  (val_a),
    .valP_i  (val_p),
    .mem     (mif.master),
    .valM_o  (val_m),
    .stat_o  (stat_out),
    .done_o  (done),
    .busy_o  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] ic, input logic [2:0] st,
                       input logic [63:0] e, input logic [63:0] a, input logic [63:0] p);
    icode   = ic;
    stat_in = st;
    val_e   = e;
    val_a   = a;
    val_p   = p;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    icode = 4'h0;
    stat_in = 3'd1;
    val_e = 64'd0;
    val_a = 64'd0;
    val_p = 64'd0;
    mif.mem_ack_i   = 1'b0;
    mif.mem_err_i   = 1'b0;
    mif.mem_rdata_i = 64'd0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_stat", 64'(stat_out), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_req", 64'(mif.mem_req_o), 64'd0);
    chk("rst_valm", val_m, 64'd0);
    chk("rst_addr", mif.mem_addr_o, 64'd0);

    // MRMOVQ zero-wait read
    issue(4'h5, 3'd1, 64'h100, 64'h7, 64'h9);
    chk("mr_req", 64'(mif.mem_req_o), 64'd1);
    chk("mr_addr", mif.mem_addr_o, 64'h100);
    chk("mr_we", 64'(mif.mem_we_o), 64'd0);
    chk("mr_busy", 64'(busy), 64'd1);
    chk("mr_done_early", 64'(done), 64'd0);
    mif.mem_ack_i   = 1'b1;
    mif.mem_rdata_i = 64'hDEADBEEF;
    tick();
    mif.mem_ack_i = 1'b0;
    chk("mr_done", 64'(done), 64'd1);
    chk("mr_valm", val_m, 64'hDEADBEEF);
    chk("mr_stat", 64'(stat_out), 64'd1);
    chk("mr_req_off", 64'(mif.mem_req_o), 64'd0);
    tick();
    chk("mr_idle", 64'(busy), 64'd0);
    chk("mr_valm_hold", val_m, 64'hDEADBEEF);

    // OPQ: non-memory op, clears valM
    issue(4'h6, 3'd1, 64'h100, 64'h0, 64'h0);
    chk("opq_req", 64'(mif.mem_req_o), 64'd0);
    chk("opq_done", 64'(done), 64'd1);
    chk("opq_stat", 64'(stat_out), 64'd1);
    chk("opq_valm", val_m, 64'd0);
    tick();

    // CALL with 3 wait cycles; start while busy is ignored
    issue(4'h8, 3'd1, 64'h1F8, 64'h999, 64'h40);
    for (int i = 0; i < 4; i++) begin
      chk("call_req", 64'(mif.mem_req_o), 64'd1);
      chk("call_we", 64'(mif.mem_we_o), 64'd1);
      chk("call_wdata", mif.mem_wdata_o, 64'h40);
      chk("call_addr", mif.mem_addr_o, 64'h1F8);
      chk("call_done_early", 64'(done), 64'd0);
      if (i == 3) begin
        mif.mem_ack_i = 1'b1;
      end
      if (i == 1) begin
        icode = 4'h5;
        val_e = 64'h300;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    mif.mem_ack_i = 1'b0;
    chk("call_done", 64'(done), 64'd1);
    chk("call_stat", 64'(stat_out), 64'd1);
    chk("call_valm", val_m, 64'd0);
    chk("call_we_off", 64'(mif.mem_we_o), 64'd0);
    tick();
    chk("call_idle", 64'(busy), 64'd0);
    chk("call_addr_hold", mif.mem_addr_o, 64'h1F8);

    // POPQ out of bounds
    issue(4'hB, 3'd1, 64'h0, 64'd8188, 64'h0);
    chk("pop_req", 64'(mif.mem_req_o), 64'd0);
    chk("pop_done", 64'(done), 64'd1);
    chk("pop_stat", 64'(stat_out), 64'd3);
    tick();

    // POPQ at last legal address, error ack
    issue(4'hB, 3'd1, 64'h0, 64'd8184, 64'h0);
    chk("edge_req", 64'(mif.mem_req_o), 64'd1);
    chk("edge_addr", mif.mem_addr_o, 64'd8184);
    mif.mem_ack_i   = 1'b1;
    mif.mem_err_i   = 1'b1;
    mif.mem_rdata_i = 64'h1234;
    tick();
    mif.mem_ack_i = 1'b0;
    mif.mem_err_i = 1'b0;
    chk("err_done", 64'(done), 64'd1);
    chk("err_stat", 64'(stat_out), 64'd3);
    chk("err_valm", val_m, 64'd0);
    tick();

    // RMMOVQ with no ack: timeout
    issue(4'h4, 3'd1, 64'h80, 64'h55, 64'h0);
    n = 0;
    while (mif.mem_req_o === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("to_cycles", 64'(n), 64'd16);
    chk("to_done", 64'(done), 64'd1);
    chk("to_stat", 64'(stat_out), 64'd3);
    tick();

    // RET with ack on the final timeout cycle: ack wins
    issue(4'h9, 3'd1, 64'h0, 64'h200, 64'h0);
    for (int i = 0; i < 15; i++) begin
      tick();
    end
    chk("late_req", 64'(mif.mem_req_o), 64'd1);
    mif.mem_ack_i   = 1'b1;
    mif.mem_rdata_i = 64'hCAFE;
    tick();
    mif.mem_ack_i = 1'b0;
    chk("late_done", 64'(done), 64'd1);
    chk("late_stat", 64'(stat_out), 64'd1);
    chk("late_valm", val_m, 64'hCAFE);
    tick();

    // PUSHQ with incoming INS status
    issue(4'hA, 3'd4, 64'h100, 64'h1, 64'h0);
    chk("ins_req", 64'(mif.mem_req_o), 64'd0);
    chk("ins_done", 64'(done), 64'd1);
    chk("ins_stat", 64'(stat_out), 64'd4);
    tick();

    // Unaligned MRMOVQ
    issue(4'h5, 3'd1, 64'h103, 64'h0, 64'h0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("ua_req", 64'(mif.mem_req_o), 64'd0);
    chk("ua_done", 64'(done), 64'd1);
    chk("ua_stat", 64'(stat_out), 64'd3);
    tick();
`else
    chk("ua_req", 64'(mif.mem_req_o), 64'd1);
    chk("ua_addr", mif.mem_addr_o, 64'h103);
    mif.mem_ack_i   = 1'b1;
    mif.mem_rdata_i = 64'h77;
    tick();
    mif.mem_ack_i = 1'b0;
    chk("ua_stat", 64'(stat_out), 64'd1);
    chk("ua_valm", val_m, 64'h77);
    tick();
`endif

    // Async reset mid-REQ
    issue(4'h5, 3'd1, 64'h40, 64'h0, 64'h0);
    chk("ar_req_pre", 64'(mif.mem_req_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req", 64'(mif.mem_req_o), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_idle", 64'(busy), 64'd0);
    chk("ar_stat", 64'(stat_out), 64'd1);
    chk("ar_done", 64'(done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
